// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers and Status/Cause bit positions shared by the CP0 interrupt block.
package cp0_pkg;
   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam int IE_BIT   = 0;
   localparam int IP_LO    = 10;
   localparam int IP_HI    = 15;
   localparam int TIMER_IP = 15;
endpackage

// File: rtl/cp0_irq_unit_if.sv
// cp0_irq_unit_if: mfc0/mtc0 access bus plus interrupt request/acknowledge handshake.
// master = pipeline side (drives addr/we/wdata/int_ack/epc_in); slave = CP0 side (drives rdata/int_req).
interface cp0_irq_unit_if;
   logic [4:0]  cp0_addr;
   logic        cp0_we;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        int_req;
   logic        int_ack;
   logic [31:0] epc_in;
   modport master (output cp0_addr, cp0_we, cp0_wdata, int_ack, epc_in, input cp0_rdata, int_req);
   modport slave  (input cp0_addr, cp0_we, cp0_wdata, int_ack, epc_in, output cp0_rdata, int_req);
endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count with Compare and a combinational match flag.
// Ports: clk/rst, we_count/we_compare + wdata (mtc0 loads), count/compare (register values), match (count == compare).
module cp0_timer #(
   parameter logic [31:0] COMPARE_RST = 32'h02FAF080
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_count,
   input  logic        we_compare,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        match
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         compare <= COMPARE_RST;
      end else begin
         count <= we_count ? wdata : count + 32'd1;
         if (we_compare) compare <= wdata;
      end
   end
   assign match = count == compare;
endmodule

// File: rtl/cp0_irq_unit.sv
// cp0_irq_unit: CP0 Count/Compare/Status/Cause/EPC with edge-latched interrupts and request/ack to the pipeline.
// Ports: clk/rst, irq_in (external lines -> Cause[14:10]), status_ie (Status[0]), bus (slave: mfc0/mtc0 + int_req/int_ack/epc_in).
module cp0_irq_unit
   import cp0_pkg::*;
#(
   parameter int          IRQ_W       = 5,
   parameter logic [31:0] COMPARE_RST = 32'h02FAF080
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IRQ_W-1:0] irq_in,
   output logic             status_ie,
   cp0_irq_unit_if.slave    bus
);
   localparam int IP_W = IP_HI - IP_LO + 1;
   logic [IRQ_W-1:0] irq_prev;
   logic [IP_W-1:0]  ip, im, hw_set;
   logic             ie, match;
   logic [31:0]      epc, count, compare;
   logic             we_count, we_compare, we_status, we_cause, we_epc;
   assign we_count   = bus.cp0_we && bus.cp0_addr == CP0_COUNT;
   assign we_compare = bus.cp0_we && bus.cp0_addr == CP0_COMPARE;
   assign we_status  = bus.cp0_we && bus.cp0_addr == CP0_STATUS;
   assign we_cause   = bus.cp0_we && bus.cp0_addr == CP0_CAUSE;
   assign we_epc     = bus.cp0_we && bus.cp0_addr == CP0_EPC;
   cp0_timer #(.COMPARE_RST(COMPARE_RST)) u_timer (
      .clk(clk), .rst(rst), .we_count(we_count), .we_compare(we_compare),
      .wdata(bus.cp0_wdata), .count(count), .compare(compare), .match(match)
   );
   // rising edges of the external lines plus the timer match, in Cause IP bit order
   always_comb begin
      hw_set = IP_W'(irq_in & ~irq_prev);
      hw_set[TIMER_IP-IP_LO] = match;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_prev <= '0;
         ip       <= '0;
         im       <= '0;
         ie       <= 1'b0;
         epc      <= '0;
      end else begin
         irq_prev <= irq_in;
         // hardware sets are OR-ed after the software load so they win over a same-cycle clear
         ip  <= (we_cause ? bus.cp0_wdata[IP_HI:IP_LO] : ip) | hw_set;
         if (we_status) im <= bus.cp0_wdata[IP_HI:IP_LO];
         ie  <= bus.int_ack ? 1'b0 : we_status ? bus.cp0_wdata[IE_BIT] : ie;
         epc <= bus.int_ack ? bus.epc_in : we_epc ? bus.cp0_wdata : epc;
      end
   end
   always_comb begin
      bus.cp0_rdata = bus.cp0_addr == CP0_COUNT   ? count :
                      bus.cp0_addr == CP0_COMPARE ? compare :
                      bus.cp0_addr == CP0_STATUS  ? {16'b0, im, 9'b0, ie} :
                      bus.cp0_addr == CP0_CAUSE   ? {16'b0, ip, 10'b0} :
                      bus.cp0_addr == CP0_EPC     ? epc : 32'b0;
   end
   assign bus.int_req = ie & |(ip & im);
   assign status_ie   = ie;
endmodule

// File: tb/tb_cp0_irq_unit.sv
// tb_cp0_irq_unit: directed vector table, timer/reset sequences and a randomized run against a reference model.
module tb_cp0_irq_unit;
   logic clk = 1'b0;
   logic rst;
   logic [4:0] irq_in;
   logic status_ie;
   int checks = 0;
   int errors = 0;
   cp0_irq_unit_if bus();
   cp0_irq_unit #(.IRQ_W(5), .COMPARE_RST(32'h02FAF080)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .status_ie(status_ie), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [4:0]  wa;
      logic        we;
      logic [31:0] wd;
      logic [4:0]  irq;
      logic        ack;
      logic [31:0] epc;
      logic [4:0]  ra;
      logic [31:0] exp_rd;
      logic        exp_req;
   } vec_t;
   vec_t tbl[15];
   logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
   logic [4:0]  m_prev;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask
   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
      bus.cp0_addr = a;
      bus.cp0_we = 1'b0;
      #1;
      chk(name, bus.cp0_rdata, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      bus.cp0_we = 1'b0;
      bus.int_ack = 1'b0;
   endtask
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.cp0_addr = a;
      bus.cp0_we = 1'b1;
      bus.cp0_wdata = d;
      tick();
   endtask
   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction
   function automatic logic m_req();
      return m_status[0] && ((m_cause & m_status & 32'h0000FC00) != 0);
   endfunction
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      rst = 1'b1;
      irq_in = '0;
      bus.cp0_addr = '0;
      bus.cp0_we = 1'b0;
      bus.cp0_wdata = '0;
      bus.int_ack = 1'b0;
      bus.epc_in = '0;
      tbl[0]  = '{5'd0,  1'b0, 32'h0,        5'h0, 1'b0, 32'h0,    5'd9,  32'h1,        1'b0};
      tbl[1]  = '{5'd0,  1'b0, 32'h0,        5'h0, 1'b0, 32'h0,    5'd9,  32'h2,        1'b0};
      tbl[2]  = '{5'd12, 1'b1, 32'h401,      5'h0, 1'b0, 32'h0,    5'd12, 32'h401,      1'b0};
      tbl[3]  = '{5'd0,  1'b0, 32'h0,        5'h1, 1'b0, 32'h0,    5'd13, 32'h400,      1'b1};
      tbl[4]  = '{5'd13, 1'b1, 32'h0,        5'h1, 1'b0, 32'h0,    5'd13, 32'h0,        1'b0};
      tbl[5]  = '{5'd0,  1'b0, 32'h0,        5'h1, 1'b0, 32'h0,    5'd13, 32'h0,        1'b0};
      tbl[6]  = '{5'd13, 1'b1, 32'h0,        5'h3, 1'b0, 32'h0,    5'd13, 32'h800,      1'b0};
      tbl[7]  = '{5'd12, 1'b1, 32'hC01,      5'h3, 1'b1, 32'h1234, 5'd12, 32'hC00,      1'b0};
      tbl[8]  = '{5'd0,  1'b0, 32'h0,        5'h3, 1'b0, 32'h0,    5'd14, 32'h1234,     1'b0};
      tbl[9]  = '{5'd14, 1'b1, 32'hDEADBEEF, 5'h3, 1'b0, 32'h0,    5'd14, 32'hDEADBEEF, 1'b0};
      tbl[10] = '{5'd9,  1'b1, 32'hFFFFFFFE, 5'h3, 1'b0, 32'h0,    5'd9,  32'hFFFFFFFE, 1'b0};
      tbl[11] = '{5'd0,  1'b0, 32'h0,        5'h3, 1'b0, 32'h0,    5'd9,  32'hFFFFFFFF, 1'b0};
      tbl[12] = '{5'd0,  1'b0, 32'h0,        5'h3, 1'b0, 32'h0,    5'd9,  32'h0,        1'b0};
      tbl[13] = '{5'd11, 1'b1, 32'h5,        5'h3, 1'b0, 32'h0,    5'd11, 32'h5,        1'b0};
      tbl[14] = '{5'd7,  1'b1, 32'h55,       5'h3, 1'b0, 32'h0,    5'd7,  32'h0,        1'b0};
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd(5'd12, 32'h0, "rst_status");
      rd(5'd13, 32'h0, "rst_cause");
      rd(5'd14, 32'h0, "rst_epc");
      rd(5'd11, 32'h02FAF080, "rst_compare");
      rd(5'd9, 32'h0, "rst_count");
      chk("rst_int_req", 32'(bus.int_req), 32'h0);
      chk("rst_status_ie", 32'(status_ie), 32'h0);
      for (int i = 0; i < 15; i++) begin
         bus.cp0_addr = tbl[i].wa;
         bus.cp0_we = tbl[i].we;
         bus.cp0_wdata = tbl[i].wd;
         irq_in = tbl[i].irq;
         bus.int_ack = tbl[i].ack;
         bus.epc_in = tbl[i].epc;
         tick();
         rd(tbl[i].ra, tbl[i].exp_rd, $sformatf("row%0d_rdata", i));
         chk($sformatf("row%0d_int_req", i), 32'(bus.int_req), 32'(tbl[i].exp_req));
      end
      wr(5'd11, 32'hFFFF0000);
      wr(5'd13, 32'h0);
      wr(5'd12, 32'h8401);
      rd(5'd9, 32'd5, "timer_count_start");
      rd(5'd13, 32'h0, "timer_cause_clear");
      wr(5'd11, 32'd25);
      n = 1;
      while (!bus.int_req && n <= 40) begin
         tick();
         n++;
      end
      chk("timer_edges_to_req", n, 21);
      rd(5'd13, 32'h8000, "timer_cause");
      bus.epc_in = 32'h100;
      bus.int_ack = 1'b1;
      tick();
      rd(5'd14, 32'h100, "ack_epc");
      rd(5'd12, 32'h8400, "ack_status");
      chk("ack_int_req", 32'(bus.int_req), 32'h0);
      chk("ack_status_ie", 32'(status_ie), 32'h0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      rd(5'd9, 32'h0, "async_rst_count");
      rd(5'd11, 32'h02FAF080, "async_rst_compare");
      rd(5'd14, 32'h0, "async_rst_epc");
      chk("async_rst_int_req", 32'(bus.int_req), 32'h0);
      irq_in = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_count = 0;
      m_compare = 32'h02FAF080;
      m_status = 0;
      m_cause = 0;
      m_epc = 0;
      m_prev = 0;
      for (int k = 0; k < 400; k++) begin
         int pool[6] = '{9, 11, 12, 13, 14, 3};
         logic [4:0]  wa;
         logic        we, ack;
         logic [31:0] wd, ep, n_cause, n_status;
         logic [4:0]  irq;
         wa = 5'(pool[$urandom_range(0, 5)]);
         we = $urandom_range(0, 2) == 0;
         wd = $urandom;
         if (wa == 5'd11) wd = m_count + 32'($urandom_range(0, 12));
         if (wa == 5'd9 && $urandom_range(0, 1) == 1) wd = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
         if (wa == 5'd12 && $urandom_range(0, 1) == 1) wd[0] = 1'b1;
         irq = 5'($urandom);
         ep = $urandom;
         ack = m_req() ? $urandom_range(0, 1) == 1 : $urandom_range(0, 19) == 0;
         bus.cp0_addr = wa;
         bus.cp0_we = we;
         bus.cp0_wdata = wd;
         irq_in = irq;
         bus.int_ack = ack;
         bus.epc_in = ep;
         n_cause = (we && wa == 5'd13) ? (wd & 32'h0000FC00) : m_cause;
         for (int i = 0; i < 5; i++)
            if (irq[i] && !m_prev[i]) n_cause[10 + i] = 1'b1;
         if (m_count == m_compare) n_cause[15] = 1'b1;
         n_status = (we && wa == 5'd12) ? (wd & 32'h0000FC01) : m_status;
         if (ack) n_status[0] = 1'b0;
         tick();
         m_epc = ack ? ep : (we && wa == 5'd14) ? wd : m_epc;
         m_compare = (we && wa == 5'd11) ? wd : m_compare;
         m_count = (we && wa == 5'd9) ? wd : m_count + 32'd1;
         m_cause = n_cause;
         m_status = n_status;
         m_prev = irq;
         begin
            logic [4:0] ra;
            ra = 5'($urandom_range(0, 31));
            rd(ra, m_read(ra), $sformatf("rand%0d_rd%0d", k, ra));
         end
         chk($sformatf("rand%0d_int_req", k), 32'(bus.int_req), 32'(m_req()));
         chk($sformatf("rand%0d_status_ie", k), 32'(status_ie), 32'(m_status[0]));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
